// File: rtl/seq_booth_mul_32_bit.sv
// Sequential radix-2 Booth multiplier: signed N x N -> 2N product, one Booth step per clock.
// The product is read straight from the A/Q working registers, so it holds until the next accepted start.
module seq_booth_mul_32_bit #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_N   = CW'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N:0]      a_r;
    logic [N-1:0]    q_r;
    logic            q_m1_r;
    logic [N:0]      m_r;
    logic [CW-1:0]   count_r;
    logic            busy_r;
    logic            done_r;
    logic            busy_s;
    logic            done_s;
    logic [N:0]      sum_s;
    logic [N:0]      a_sh_s;
    logic [N-1:0]    q_sh_s;
    logic            q_m1_sh_s;

    // Booth recoding: add or subtract M depending on the current bit pair.
    always_comb begin
        sum_s = a_r;
        case ({q_r[0], q_m1_r})
            2'b01:   sum_s = a_r + m_r;
            2'b10:   sum_s = a_r - m_r;
            default: sum_s = a_r;
        endcase
    end

    // Arithmetic right shift of {A, Q, q_m1}; A is N+1 bits so M = -2^(N-1) cannot overflow.
    assign a_sh_s    = {sum_s[N], sum_s[N:1]};
    assign q_sh_s    = {sum_s[0], q_r[N-1:1]};
    assign q_m1_sh_s = q_r[0];

    // State register plus registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done line up with the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath: load operands on accept, one Booth step per RUN cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            q_r     <= '0;
            q_m1_r  <= 1'b0;
            m_r     <= '0;
            count_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= '0;
                        q_r     <= multiplier;
                        q_m1_r  <= 1'b0;
                        m_r     <= {multiplicand[N-1], multiplicand};
                        count_r <= CNT_N;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_sh_s;
                    q_r     <= q_sh_s;
                    q_m1_r  <= q_m1_sh_s;
                    count_r <= count_r - CNT_ONE;
                end
                default: begin
                    a_r     <= a_r;
                    q_r     <= q_r;
                    q_m1_r  <= q_m1_r;
                    m_r     <= m_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = {a_r[N-1:0], q_r};

endmodule
